// File: rtl/rah_app_mux_if.sv
// App-side and encoder-side signal bundle for rah_app_mux.
// Stat ports exist only when RAH_APP_MUX_STATS_EN is defined.
interface rah_app_mux_if #(
    parameter int N = 3,
    parameter int W = 48
);
    logic [N-1:0]   app_wr_en;
    logic [N*W-1:0] app_wr_data;
    logic [N-1:0]   app_full;
    logic [N-1:0]   app_overflow;
    logic           enc_prog_full;
    logic [N-1:0]   enc_send_data;
    logic [W-1:0]   enc_wr_data;
`ifdef RAH_APP_MUX_STATS_EN
    logic [N*32-1:0] stat_words;
    logic [N*16-1:0] stat_drops;
`endif

    modport slave (
        input  app_wr_en, app_wr_data, enc_prog_full,
        output app_full, app_overflow, enc_send_data, enc_wr_data
`ifdef RAH_APP_MUX_STATS_EN
        , output stat_words, stat_drops
`endif
    );

    modport master (
        output app_wr_en, app_wr_data, enc_prog_full,
        input  app_full, app_overflow, enc_send_data, enc_wr_data
`ifdef RAH_APP_MUX_STATS_EN
        , input stat_words, stat_drops
`endif
    );
endinterface

// File: rtl/rah_app_mux.sv
// Per-app FIFOs, round-robin burst arbiter onto one encoder write port.
// Optional per-channel counters under RAH_APP_MUX_STATS_EN.
module rah_app_mux #(
    parameter int TOTAL_APPS       = 3,
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int DEPTH            = 4,
    parameter int BURST_LEN        = 2
) (
    input logic          clk,
    input logic          rst,
    rah_app_mux_if.slave bus
);
    localparam int N  = TOTAL_APPS;
    localparam int W  = RAH_PACKET_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    logic [W-1:0]  r_mem  [N][DEPTH];
    logic [AW-1:0] r_wptr [N];
    logic [AW-1:0] r_rptr [N];
    logic [AW:0]   r_cnt  [N];
    logic [N-1:0]  r_ovf;
    logic [N-1:0]  r_send;
    logic [W-1:0]  r_data;
    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_rr;
    logic [BW-1:0] r_burst;

    logic [N-1:0]  w_full, w_empty, w_wr, w_drop, w_pop;
    logic          w_any, w_gpop, w_last;
    logic [GW-1:0] w_next;
    int            w_idx;

    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_wr    = '0;
        w_drop  = '0;
        for (int i = 0; i < N; i++) begin
            w_full[i]  = (r_cnt[i] == (AW+1)'(DEPTH));
            w_empty[i] = (r_cnt[i] == '0);
            w_wr[i]    = bus.app_wr_en[i] & ~w_full[i];
            w_drop[i]  = bus.app_wr_en[i] & w_full[i];
        end
        w_gpop = (r_state == GRANT) && !bus.enc_prog_full && !w_empty[r_grant];
        w_pop  = '0;
        if (w_gpop)
            w_pop[r_grant] = 1'b1;
        w_last = w_gpop && ((r_burst + BW'(1) == BW'(BURST_LEN)) ||
                            (r_cnt[r_grant] == (AW+1)'(1)));
        // Walk backwards so the nearest channel after r_rr wins.
        w_any  = 1'b0;
        w_next = r_rr;
        w_idx  = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(r_rr) + k) % N;
            if (!w_empty[w_idx]) begin
                w_any  = 1'b1;
                w_next = GW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (w_wr[i])
                r_mem[i][r_wptr[i]] <= bus.app_wr_data[i*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_wr[i])
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                if (w_wr[i] && !w_pop[i])
                    r_cnt[i] <= r_cnt[i] + (AW+1)'(1);
                else if (!w_wr[i] && w_pop[i])
                    r_cnt[i] <= r_cnt[i] - (AW+1)'(1);
                if (w_drop[i])
                    r_ovf[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rr    <= GW'(N - 1);
            r_grant <= '0;
            r_burst <= '0;
            r_send  <= '0;
            r_data  <= '0;
        end else begin
            r_send <= w_pop;
            if (w_gpop)
                r_data <= r_mem[r_grant][r_rptr[r_grant]];
            unique case (r_state)
                IDLE: begin
                    if (w_any && !bus.enc_prog_full) begin
                        r_grant <= w_next;
                        r_rr    <= w_next;
                        r_burst <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.enc_prog_full) begin
                        if (w_gpop)
                            r_burst <= r_burst + BW'(1);
                        if (w_last || w_empty[r_grant])
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.app_full      = w_full;
    assign bus.app_overflow  = r_ovf;
    assign bus.enc_send_data = r_send;
    assign bus.enc_wr_data   = r_data;

`ifdef RAH_APP_MUX_STATS_EN
    logic [31:0] r_words [N];
    logic [15:0] r_drops [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_words[i] <= '0;
                r_drops[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_pop[i])
                    r_words[i] <= r_words[i] + 32'd1;
                if (w_drop[i])
                    r_drops[i] <= r_drops[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat
        assign bus.stat_words[g*32 +: 32] = r_words[g];
        assign bus.stat_drops[g*16 +: 16] = r_drops[g];
    end
`endif
endmodule
